// File: rtl/alu_pkg.sv
// Shared ALU op-select constants and sequencer state encoding.
// Imported by blocks that drive the team 16-bit ALU.
package alu_pkg;

  localparam logic [4:0] ALU_OP_PASS_A = 5'h00;
  localparam logic [4:0] ALU_OP_AND    = 5'h01;
  localparam logic [4:0] ALU_OP_OR     = 5'h02;
  localparam logic [4:0] ALU_OP_XOR    = 5'h03;
  localparam logic [4:0] ALU_OP_ADD    = 5'h09;
  localparam logic [4:0] ALU_OP_SUB    = 5'h0A;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned 16x16->32 shift-and-add multiplier; every add is done by an
// external ALU. Ports: clk, rst_n, start/mcand/mplier in; busy, done,
// prod_hi/lo, prod_zero out; alu_a/b/op/swap out, alu_q/alu_carry in.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  output logic             alu_swap,
  input  logic [WIDTH-1:0] alu_q,
  input  logic             alu_carry
);

  seq_state_t state, state_nxt;

  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       count;
  logic [WIDTH:0]   sum;
  logic             load;

  // start only accepted when not iterating
  assign load = start && (state != SEQ_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE: if (start) state_nxt = SEQ_RUN;
      SEQ_RUN:  if (count == 4'd15) state_nxt = SEQ_DONE;
      SEQ_DONE: state_nxt = start ? SEQ_RUN : SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SEQ_RUN:  busy = 1'b1;
      SEQ_DONE: done = 1'b1;
      default:  ;
    endcase
  end

  // ALU adds the multiplicand into the upper half; the
  // 17-bit result is shifted right one place into hi:lo
  assign alu_a    = hi;
  assign alu_b    = mc;
  assign alu_op   = ALU_OP_ADD;
  assign alu_swap = 1'b0;

  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) sum = {alu_carry, alu_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc    <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else if (load) begin
      mc    <= mcand;
      hi    <= '0;
      lo    <= mplier;
      count <= '0;
    end else if (state == SEQ_RUN) begin
      hi    <= sum[WIDTH:1];
      lo    <= {sum[0], lo[WIDTH-1:1]};
      count <= count + 4'd1;
    end
  end

  assign prod_hi   = hi;
  assign prod_lo   = lo;
  assign prod_zero = (hi == '0) && (lo == '0);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with an A+B ALU model on the alu_* ports.
// Products are checked against plain 32-bit multiplication.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic        prod_zero;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_op;
  logic        alu_swap;
  logic [15:0] alu_q;
  logic        alu_carry;

  int n_cmp;
  int n_bad;

  alu_mul_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo),
    .prod_zero(prod_zero),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_swap(alu_swap),
    .alu_q(alu_q), .alu_carry(alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external ALU: only the add op matters here
  always_comb begin
    {alu_carry, alu_q} = 17'h0;
    if (alu_op == alu_pkg::ALU_OP_ADD)
      {alu_carry, alu_q} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  // drive a one-cycle start pulse; returns at the negedge after
  // the sampling edge with start low again
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // count negedges until done (bounded); optionally inject a
  // stray start at negedge number inj
  task automatic wait_done(input int inj, output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    while (cyc < 40) begin
      cyc++;
      if (done) break;
      if (busy) nb++;
      if (cyc == inj) begin
        start  = 1'b1;
        mcand  = 16'hBEEF;
        mplier = 16'h7777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // count done pulses over a window
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic check_prod(input string nm, input logic [31:0] exp);
    n_cmp++;
    if ({prod_hi, prod_lo} !== exp) begin
      n_bad++;
      $display("FAIL %s prod got %h want %h", nm, {prod_hi, prod_lo}, exp);
    end
    n_cmp++;
    if (prod_zero !== (exp == 32'h0)) begin
      n_bad++;
      $display("FAIL %s prod_zero got %b want %b", nm, prod_zero, exp == 32'h0);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #3;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset busy/done got %b want 00", {busy, done});
    end
    check_prod("reset", 32'h0);
    n_cmp++;
    if ({alu_op, alu_swap} !== {5'h09, 1'b0}) begin
      n_bad++;
      $display("FAIL reset alu_op/swap got %h/%b want 09/0", alu_op, alu_swap);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, nb;
    launch(16'h0003, 16'h0005);
    n_cmp++;
    if (alu_b !== 16'h0003 || alu_op !== 5'h09 || alu_swap !== 1'b0) begin
      n_bad++;
      $display("FAIL basic alu drive got b=%h op=%h sw=%b want 0003/09/0",
               alu_b, alu_op, alu_swap);
    end
    wait_done(0, cyc, nb);
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL basic latency got %0d want 17", cyc);
    end
    n_cmp++;
    if (nb !== 16) begin
      n_bad++;
      $display("FAIL basic busy cycles got %0d want 16", nb);
    end
    check_prod("basic", 32'h0000_000F);
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL basic after-done busy/done got %b want 00", {busy, done});
    end
    check_prod("basic hold", 32'h0000_000F);
  endtask

  task automatic test_max;
    int cyc, nb;
    launch(16'hFFFF, 16'hFFFF);
    wait_done(0, cyc, nb);
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL max latency got %0d want 17", cyc);
    end
    check_prod("max", 32'hFFFE_0001);
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int cyc, nb, p;
    launch(16'h1234, 16'h0000);
    wait_done(5, cyc, nb);
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL ignore latency got %0d want 17", cyc);
    end
    check_prod("ignore", 32'h0);
    count_done(25, p);
    n_cmp++;
    if (p !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore extra done/busy got %0d/%b want 0/0", p, busy);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, nb, p;
    launch(16'hABCD, 16'h5A5A);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst busy/done got %b want 00", {busy, done});
    end
    check_prod("midrst", 32'h0);
    count_done(20, p);
    n_cmp++;
    if (p !== 0) begin
      n_bad++;
      $display("FAIL midrst done pulses got %0d want 0", p);
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(16'h0100, 16'h0100);
    wait_done(0, cyc, nb);
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL postrst latency got %0d want 17", cyc);
    end
    check_prod("postrst", 32'h0001_0000);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, nb;
    launch(16'h0009, 16'h0009);
    wait_done(0, cyc, nb);
    check_prod("b2b first", 32'h0000_0051);
    launch(16'h0002, 16'h0007);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b busy/done got %b want 10", {busy, done});
    end
    wait_done(0, cyc, nb);
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL b2b latency got %0d want 17", cyc);
    end
    check_prod("b2b", 32'h0000_000E);
    @(negedge clk);
  endtask

  task automatic test_random;
    int cyc, nb;
    logic [15:0] a, b;
    logic [31:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) a = 16'hFFFF;
      if (i == 1) b = 16'h8000;
      exp = 32'(a) * 32'(b);
      launch(a, b);
      wait_done(0, cyc, nb);
      n_cmp++;
      if (cyc !== 17) begin
        n_bad++;
        $display("FAIL rand%0d latency got %0d want 17", i, cyc);
      end
      check_prod($sformatf("rand%0d", i), exp);
      if (($urandom & 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_max();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
